// File: rtl/riscv_alu_issue_pkg.sv
// rtl/riscv_alu_issue_pkg.sv - shared ALU control codes, RV32I opcode constants and decoded-op struct
package riscv_alu_issue_pkg;

    localparam logic [4:0] ALU_NONE  = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADDI  = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_ORI   = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_XORI  = 5'd6;
    localparam logic [4:0] ALU_AND   = 5'd7;
    localparam logic [4:0] ALU_ANDI  = 5'd8;
    localparam logic [4:0] ALU_SUB   = 5'd9;
    localparam logic [4:0] ALU_SLT   = 5'd10;
    localparam logic [4:0] ALU_SLTI  = 5'd11;
    localparam logic [4:0] ALU_SLTU  = 5'd12;
    localparam logic [4:0] ALU_SLTIU = 5'd13;
    localparam logic [4:0] ALU_SLLI  = 5'd14;
    localparam logic [4:0] ALU_SRLI  = 5'd15;
    localparam logic [4:0] ALU_SRAI  = 5'd16;
    localparam logic [4:0] ALU_SLL   = 5'd17;
    localparam logic [4:0] ALU_SRL   = 5'd18;
    localparam logic [4:0] ALU_SRA   = 5'd19;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/riscv_alu_issue_decode.sv
// rtl/riscv_alu_issue_decode.sv - combinational RV32I OP/OP-IMM decode into ALU control fields
module riscv_alu_decode
    import riscv_alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  alu_ctrl_o,
    output logic        bsel_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];
    assign rd_o   = instr_i[11:7];

    always_comb begin
        alu_ctrl_o = ALU_NONE;
        bsel_o     = 1'b0;
        imm_o      = 32'd0;
        illegal_o  = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  alu_ctrl_o = ALU_ADD;
                        3'b001:  alu_ctrl_o = ALU_SLL;
                        3'b010:  alu_ctrl_o = ALU_SLT;
                        3'b011:  alu_ctrl_o = ALU_SLTU;
                        3'b100:  alu_ctrl_o = ALU_XOR;
                        3'b101:  alu_ctrl_o = ALU_SRL;
                        3'b110:  alu_ctrl_o = ALU_OR;
                        default: alu_ctrl_o = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    alu_ctrl_o = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    alu_ctrl_o = ALU_SRA;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OPIMM: begin
                bsel_o = 1'b1;
                imm_o  = {{20{instr_i[31]}}, instr_i[31:20]};
                case (f3)
                    3'b000: alu_ctrl_o = ALU_ADDI;
                    3'b010: alu_ctrl_o = ALU_SLTI;
                    3'b011: alu_ctrl_o = ALU_SLTIU;
                    3'b100: alu_ctrl_o = ALU_XORI;
                    3'b110: alu_ctrl_o = ALU_ORI;
                    3'b111: alu_ctrl_o = ALU_ANDI;
                    3'b001: begin
                        // Shift immediates carry only the 5-bit shamt, zero-extended.
                        imm_o = {27'd0, instr_i[24:20]};
                        if (f7 == F7_BASE) alu_ctrl_o = ALU_SLLI;
                        else               illegal_o  = 1'b1;
                    end
                    default: begin
                        imm_o = {27'd0, instr_i[24:20]};
                        if (f7 == F7_BASE)     alu_ctrl_o = ALU_SRLI;
                        else if (f7 == F7_ALT) alu_ctrl_o = ALU_SRAI;
                        else                   illegal_o  = 1'b1;
                    end
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - decode/issue stage with 2-entry skid buffer and illegal-op counter
module riscv_alu_issue
    import riscv_alu_issue_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       ALU_Ctrl,
    output logic             Bsel,
    output logic [31:0]      Imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t             dec;
    dec_t             head_q, head_d, skid_q, skid_d;
    logic             head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, pop;

    riscv_alu_decode u_decode (
        .instr_i    (Instr),
        .alu_ctrl_o (dec.ctrl),
        .bsel_o     (dec.bsel),
        .imm_o      (dec.imm),
        .rs1_o      (dec.rs1),
        .rs2_o      (dec.rs2),
        .rd_o       (dec.rd),
        .illegal_o  (dec.illegal)
    );

    assign accept = in_valid & in_ready_q;
    assign pop    = head_vld_q & out_ready;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;
        if (pop && head_q.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            // A held skid entry means in_ready was low, so no accept can coincide.
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                head_d = dec;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (head_vld_q) begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end else begin
                head_d     = dec;
                head_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= ~skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = head_vld_q;
    assign ALU_Ctrl    = head_q.ctrl;
    assign Bsel        = head_q.bsel;
    assign Imm         = head_q.imm;
    assign rs1         = head_q.rs1;
    assign rs2         = head_q.rs2;
    assign rd          = head_q.rd;
    assign illegal     = head_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb/tb_riscv_alu_issue.sv - directed self-checking bench for riscv_alu_issue
module tb_riscv_alu_issue;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [31:0]   Instr;
    logic          in_ready, out_valid, Bsel, illegal;
    logic [4:0]    ALU_Ctrl, rs1, rs2, rd;
    logic [31:0]   Imm;
    logic [CW-1:0] illegal_cnt;

    int vectors = 0;
    int miscompares = 0;

    riscv_alu_issue #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .out_valid(out_valid), .out_ready(out_ready), .ALU_Ctrl(ALU_Ctrl),
        .Bsel(Bsel), .Imm(Imm), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || ALU_Ctrl !== 5'd0 || Imm !== 32'd0 ||
            rd !== 5'd0 || illegal !== 1'b0 || illegal_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: ov=%b ir=%b ctrl=%0d imm=%h rd=%0d ill=%b cnt=%0d, want all 0",
                     out_valid, in_ready, ALU_Ctrl, Imm, rd, illegal, illegal_cnt);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  ctrl;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
    } vec_t;

    task automatic test_decode();
        vec_t v[7];
        v[0] = '{32'h00500093, 5'd2,  1'b1, 32'h00000005, 5'd0, 5'd5,  5'd1};
        v[1] = '{32'h402081B3, 5'd9,  1'b0, 32'h00000000, 5'd1, 5'd2,  5'd3};
        v[2] = '{32'h40335293, 5'd16, 1'b1, 32'h00000003, 5'd6, 5'd3,  5'd5};
        v[3] = '{32'hFFF00093, 5'd2,  1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1};
        v[4] = '{32'h01F11093, 5'd14, 1'b1, 32'h0000001F, 5'd2, 5'd31, 5'd1};
        v[5] = '{32'h0F02F213, 5'd8,  1'b1, 32'h000000F0, 5'd5, 5'd16, 5'd4};
        v[6] = '{32'h009433B3, 5'd12, 1'b0, 32'h00000000, 5'd8, 5'd9,  5'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            Instr    = v[i].instr;
            step();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || ALU_Ctrl !== v[i].ctrl || Bsel !== v[i].bsel ||
                Imm !== v[i].imm || rs1 !== v[i].rs1 || rs2 !== v[i].rs2 || rd !== v[i].rd ||
                illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL decode[%0d]: ov=%b ctrl=%0d bsel=%b imm=%h rs1=%0d rs2=%0d rd=%0d ill=%b, want 1 %0d %b %h %0d %0d %0d 0",
                         i, out_valid, ALU_Ctrl, Bsel, Imm, rs1, rs2, rd, illegal,
                         v[i].ctrl, v[i].bsel, v[i].imm, v[i].rs1, v[i].rs2, v[i].rd);
            end
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL decode_drain[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins[4];
        logic [1:0]  exp_cnt[4];
        ins[0] = 32'h00000073; exp_cnt[0] = 2'd1;
        ins[1] = 32'h02000033; exp_cnt[1] = 2'd2;
        ins[2] = 32'h00000073; exp_cnt[2] = 2'd3;
        ins[3] = 32'h02000033; exp_cnt[3] = 2'd3;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            Instr    = ins[i];
            step();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || ALU_Ctrl !== 5'd0 || Bsel !== 1'b0 ||
                Imm !== 32'd0) begin
                miscompares++;
                $display("FAIL illegal[%0d]: ov=%b ill=%b ctrl=%0d bsel=%b imm=%h, want 1 1 0 0 0",
                         i, out_valid, illegal, ALU_Ctrl, Bsel, Imm);
            end
            step();
            vectors++;
            if (illegal_cnt !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL illegal_cnt[%0d]: got %0d, want %0d", i, illegal_cnt, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins[3];
        logic [4:0]  exp_rd[3];
        ins[0] = 32'h00500093; exp_rd[0] = 5'd1;
        ins[1] = 32'h402081B3; exp_rd[1] = 5'd3;
        ins[2] = 32'h40335293; exp_rd[2] = 5'd5;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            Instr    = ins[i];
            step();
            vectors++;
            if (out_valid !== 1'b1 || rd !== exp_rd[i] || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream[%0d]: ov=%b rd=%0d ir=%b, want 1 %0d 1",
                         i, out_valid, rd, in_ready, exp_rd[i]);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[3];
        ins[0] = 32'h00500093;
        ins[1] = 32'h402081B3;
        ins[2] = 32'h40335293;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            Instr    = ins[i];
            step();
        end
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 5'd1 || ALU_Ctrl !== 5'd2) begin
            miscompares++;
            $display("FAIL full_hold: ir=%b ov=%b rd=%0d ctrl=%0d, want 0 1 1 2",
                     in_ready, out_valid, rd, ALU_Ctrl);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || rd !== 5'd3 || ALU_Ctrl !== 5'd9 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: ov=%b rd=%0d ctrl=%0d ir=%b, want 1 3 9 1",
                     out_valid, rd, ALU_Ctrl, in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || rd !== 5'd5 || ALU_Ctrl !== 5'd16) begin
            miscompares++;
            $display("FAIL b2b_third: ov=%b rd=%0d ctrl=%0d, want 1 5 16", out_valid, rd, ALU_Ctrl);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: out_valid=%b, want 0 (duplicate)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Instr     = 32'h00500093;
        step();
        Instr     = 32'h402081B3;
        step();
        Instr     = 32'h40335293;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: ov=%b ir=%b, want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        Instr    = 32'h00500093;
        step();
        Instr    = 32'h402081B3;
        flush    = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_accept: ov=%b ir=%b, want 0 1", out_valid, in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_nothing_issued: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Instr     = 32'h402081B3;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || ALU_Ctrl !== 5'd0 || Bsel !== 1'b0 ||
            Imm !== 32'd0 || rs1 !== 5'd0 || rs2 !== 5'd0 || rd !== 5'd0 || illegal !== 1'b0 ||
            illegal_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_mid: ov=%b ir=%b ctrl=%0d imm=%h rs1=%0d rs2=%0d rd=%0d cnt=%0d, want all 0",
                     out_valid, in_ready, ALU_Ctrl, Imm, rs1, rs2, rd, illegal_cnt);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_release: ir=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Instr     = 32'h00500093;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALU_Ctrl !== 5'd2 || Imm !== 32'd5 || rd !== 5'd1) begin
            miscompares++;
            $display("FAIL reset_mid_resume: ov=%b ctrl=%0d imm=%h rd=%0d, want 1 2 5 1",
                     out_valid, ALU_Ctrl, Imm, rd);
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Instr     = 32'd0;
        test_reset();
        test_decode();
        test_illegal();
        test_stream();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
